// File: rtl/adder_tree_sequencer_if.sv
// rtl/adder_tree_sequencer_if.sv - vector handshake, shared-tree and result signals
// master drives the vector and consumes the result; slave is the sequencer.
interface adder_tree_sequencer_if #(
  parameter int N_STAGE = 5,
  parameter int N_CHUNK = 4,
  parameter int ACC_W   = N_STAGE + 2 + $clog2(N_CHUNK)
);
  localparam int CW = 2 ** (N_STAGE + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [N_CHUNK*CW-1:0]     wx_in;
  logic [CW-1:0]             tree_wx;
  logic signed [N_STAGE+1:0] tree_y;
  logic signed [ACC_W-1:0]   sum_out;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;

  modport master (
    output in_valid, wx_in, tree_y, out_ready,
    input  in_ready, tree_wx, sum_out, out_valid, busy
  );

  modport slave (
    input  in_valid, wx_in, tree_y, out_ready,
    output in_ready, tree_wx, sum_out, out_valid, busy
  );
endinterface

// File: rtl/adder_tree_sequencer.sv
// rtl/adder_tree_sequencer.sv - time-multiplexes an external adder tree over N_CHUNK chunks
// Captures a wide vector, feeds one chunk per cycle, accumulates, then holds the total.
module adder_tree_sequencer #(
  parameter int N_STAGE = 5,
  parameter int N_CHUNK = 4,
  parameter int ACC_W   = N_STAGE + 2 + $clog2(N_CHUNK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_tree_sequencer_if.slave bus
);
  localparam int CW    = 2 ** (N_STAGE + 1);
  localparam int W     = N_CHUNK * CW;
  localparam int IDX_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CHUNK - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [W-1:0]            wx_q, wx_d;
  logic                    out_valid_q, out_valid_d;

  logic [CW-1:0]           chunk [N_CHUNK];
  logic signed [ACC_W-1:0] y_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    in_ready;

  for (genvar k = 0; k < N_CHUNK; k++) begin : g_chunk
    assign chunk[k] = wx_q[k*CW +: CW];
  end

  // Tree input is forced to zero outside ACCUM so the shared tree stays quiet.
  assign bus.tree_wx = (state_q == ACCUM) ? chunk[idx_q] : '0;
  assign y_ext       = ACC_W'(bus.tree_y);
  assign acc_sum     = acc_q + y_ext;

  assign in_ready      = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.in_ready  = in_ready;
  assign bus.sum_out   = sum_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    wx_d        = wx_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          wx_d    = bus.wx_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (idx_q == LAST) begin
          idx_d       = '0;
          sum_d       = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          // Consume and accept on the same edge keeps the pipe at N_CHUNK+1 cycles.
          if (bus.in_valid) begin
            wx_d    = bus.wx_in;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      wx_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      wx_q        <= wx_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_adder_tree_sequencer.sv
// tb/tb_adder_tree_sequencer.sv - scoreboard bench with a behavioural adder tree
module tb_adder_tree_sequencer;
  localparam int N_STAGE = 5;
  localparam int N_CHUNK = 4;
  localparam int ACC_W   = 9;
  localparam int CW      = 64;
  localparam int W       = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_tree_sequencer_if #(.N_STAGE(N_STAGE), .N_CHUNK(N_CHUNK), .ACC_W(ACC_W)) bus ();

  adder_tree_sequencer #(.N_STAGE(N_STAGE), .N_CHUNK(N_CHUNK), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic signed [N_STAGE+1:0] tree_sum(input logic [CW-1:0] c);
    int s = 0;
    for (int i = 0; i < CW / 2; i++) s += int'($signed(c[2*i +: 2]));
    return (N_STAGE + 2)'(s);
  endfunction

  assign bus.tree_y = tree_sum(bus.tree_wx);

  function automatic int gold(input logic [W-1:0] v);
    int s = 0;
    for (int i = 0; i < W / 2; i++) s += int'($signed(v[2*i +: 2]));
    return s;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  int sb_q[$];
  int cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pop before push so a same-edge consume/accept pairs the older result first.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_result", 1, 0);
        else check("sb_sum", int'(bus.sum_out), sb_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(gold(bus.wx_in));
    end
  end

  task automatic drive(input logic [W-1:0] v);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.wx_in    = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.wx_in    = rand_vec();
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = i; break; end
    end
  endtask

  task automatic run_one(input logic [W-1:0] v, input int exp, input string tag);
    int lat;
    drive(v);
    check({tag, "_busy"}, int'(bus.busy), 1);
    wait_valid(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, int'(bus.sum_out), exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, int'(bus.out_valid), 0);
    check({tag, "_idle"}, int'(bus.busy), 0);
    check({tag, "_tree_quiet"}, int'(bus.tree_wx != '0), 0);
  endtask

  initial begin
    logic [W-1:0] p01, p10, mix, v;
    int lat, held, last_acc, ok;
    p01 = {128{2'b01}};
    p10 = {128{2'b10}};
    mix = {{32{2'b10}}, {32{2'b11}}, {32{2'b00}}, {32{2'b01}}};
    bus.in_valid  = 1'b0;
    bus.wx_in     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_sum", int'(bus.sum_out), 0);
      check("rst_tree_wx", int'(bus.tree_wx != '0), 0);
      check("rst_busy", int'(bus.busy), 0);
    end

    run_one(p01, 128, "all01");
    run_one(p10, -256, "all10");
    run_one(mix, -64, "mixed");
    for (int i = 0; i < 3; i++) begin
      v = rand_vec();
      run_one(v, gold(v), "rand");
    end

    // Backpressure: result must hold while stray in_valid pulses are ignored.
    bus.out_ready = 1'b0;
    v = rand_vec();
    drive(v);
    wait_valid(lat);
    check("bp_latency", lat, 4);
    held = int'(bus.sum_out);
    check("bp_sum", held, gold(v));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.wx_in    = rand_vec();
      @(posedge clk); #1;
      check("bp_valid_hold", int'(bus.out_valid), 1);
      check("bp_sum_hold", int'(bus.sum_out), held);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", int'(bus.busy), 0);
    check("bp_release_valid", int'(bus.out_valid), 0);

    // Back-to-back stream with in_valid held high across same-edge handoffs.
    last_acc = -1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.wx_in = rand_vec();
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.in_ready) begin ok = 1; break; end
      end
      if (ok == 0) check("stream_accept_timeout", 0, 1);
      if (last_acc >= 0) check("stream_gap", cyc - last_acc, 5);
      last_acc = cyc;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.wx_in    = rand_vec();
    repeat (8) @(posedge clk);
    #1;
    check("stream_drain", sb_q.size(), 0);

    // Asynchronous reset in the second ACCUM cycle.
    drive(rand_vec());
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_tree_wx", int'(bus.tree_wx != '0), 0);
    check("mid_rst_sum", int'(bus.sum_out), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", int'(bus.out_valid), 0);
    end
    v = rand_vec();
    run_one(v, gold(v), "post_rst");
    run_one(p01, 128, "post_rst_all01");

    repeat (3) @(posedge clk);
    check("final_sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
